// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb_if
// Brief    : Requester byte handshakes plus the uart_tx launch/done pair.
// Revision : 1.0
// ============================================================================
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_en;
    logic               tx_done;

    // master: requesters and the uart_tx byte engine; slave: the arbiter
    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_data, tx_en
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_data, tx_en
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Round-robin arbiter sharing one uart_tx among N_REQ requesters,
//            with message lock, lock-gap release and tx_done watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_arb #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 8192,
    parameter int LOCK_GAP    = 16,
    localparam int GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic    uclk,
    input  wire logic    rst_n,
    uart_tx_arb_if.slave bus,
    input  wire logic    i_err_clr,
    output logic [GW-1:0] o_grant_id,
    output logic         o_busy,
    output logic         o_timeout_err
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LW = (LOCK_GAP > 2) ? $clog2(LOCK_GAP) : 1;
    localparam logic [CW-1:0] c_WAIT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] c_GAP_LAST  = LW'(LOCK_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_LAUNCH = 4'b0010,
        S_WAIT   = 4'b0100,
        S_ERR    = 4'b1000
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_rr_ptr;
    logic [GW-1:0] r_grant_id;
    logic          r_lock;
    logic          r_last;
    logic [7:0]    r_tx_data;
    logic          r_timeout_err;
    logic [CW-1:0] r_wait_cnt;
    logic [LW-1:0] r_gap_cnt;

    logic [GW-1:0]    w_win_id;
    logic             w_win_vld;
    logic [GW-1:0]    w_idx;
    logic [7:0]       w_win_data;
    logic             w_win_last;
    logic [N_REQ-1:0] w_ready;
    logic             w_xfer;
    logic             w_done;
    logic             w_tmo;
    logic             w_clr;
    logic             w_gap_tick;

    // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        w_win_id  = r_grant_id;
        w_win_vld = 1'b0;
        w_idx     = '0;
        if (r_lock) begin
            w_win_vld = bus.req_valid[r_grant_id];
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                w_idx = GW'((int'(r_rr_ptr) + k) % N_REQ);
                if (bus.req_valid[w_idx]) begin
                    w_win_id  = w_idx;
                    w_win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_win_data = 8'h00;
        w_win_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win_id == GW'(i)) begin
                w_win_data = bus.req_data[8*i +: 8];
                w_win_last = bus.req_last[i];
            end
        end
    end

    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_xfer      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_ready[w_win_id] = 1'b1;
                    w_xfer            = 1'b1;
                    w_state_nxt       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the final watchdog cycle still counts as success.
                if (bus.tx_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                if (i_err_clr) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_gap_tick = (r_state == S_IDLE) && r_lock && !bus.req_valid[r_grant_id];

    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= GW'(N_REQ - 1);
            r_grant_id    <= '0;
            r_lock        <= 1'b0;
            r_last        <= 1'b0;
            r_tx_data     <= 8'h00;
            r_timeout_err <= 1'b0;
            r_wait_cnt    <= '0;
            r_gap_cnt     <= '0;
        end else begin
            if (w_xfer) begin
                r_tx_data  <= w_win_data;
                r_last     <= w_win_last;
                r_grant_id <= w_win_id;
                r_gap_cnt  <= '0;
            end else if (w_gap_tick) begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    r_lock    <= 1'b0;
                    r_gap_cnt <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
            end

            if (r_state == S_LAUNCH) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_done) begin
                if (r_last) begin
                    r_lock   <= 1'b0;
                    r_rr_ptr <= r_grant_id;
                end else begin
                    r_lock <= 1'b1;
                end
            end

            if (w_tmo) begin
                r_timeout_err <= 1'b1;
                r_lock        <= 1'b0;
            end

            if (w_clr) begin
                r_timeout_err <= 1'b0;
                r_rr_ptr      <= r_grant_id;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_en      = (r_state == S_LAUNCH);
    assign o_grant_id     = r_grant_id;
    assign o_busy         = (r_state != S_IDLE);
    assign o_timeout_err  = r_timeout_err;

    a_tx_en_single: assert property (@(posedge uclk) disable iff (!rst_n)
        bus.tx_en |=> !bus.tx_en);
    a_ready_onehot: assert property (@(posedge uclk) disable iff (!rst_n)
        $onehot0(bus.req_ready));
    a_tx_en_launch: assert property (@(posedge uclk) disable iff (!rst_n)
        bus.tx_en |-> (r_state == S_LAUNCH));

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter and sequencer that shares one uart_tx byte transmitter among N_REQ requesters. It accepts bytes over per-requester valid/ready handshakes and launches each byte with a single-cycle tx_en pulse. It waits for tx_done before starting the next byte, can lock the grant for multi-byte messages, and traps a lost tx_done with a watchdog.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 8192, WAIT cycles without tx_done before error (frame at 50 MHz/115200 is about 4340 cycles)
LOCK_GAP, 16, idle cycles a locked requester may leave req_valid low before the lock is dropped

Ports:
uclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  N_REQ  byte is last of message (1 = single byte / end of message)
req_ready  out  N_REQ  per-requester accept; transfer when valid and ready
tx_data  out  8  byte to uart_tx, registered
tx_en  out  1  one-cycle launch pulse to uart_tx
tx_done  in  1  one-cycle completion pulse from uart_tx
grant_id  out  clog2(N_REQ)  requester owning current/last byte
busy  out  1  state is not IDLE
timeout_err  out  1  sticky watchdog error
err_clr  in  1  clears timeout_err and leaves ERR

Behaviour:
- Interface: clock uclk; reset rst_n, asynchronous, active-low.
- Reset values:
  - Outputs: state IDLE, tx_en=0, tx_data=0, grant_id=0, req_ready=0, timeout_err=0.
  - Internals: rr_ptr=N_REQ-1, so requester 0 wins first; lock=0; counters 0.
- States: IDLE, LAUNCH, WAIT, ERR (one-hot).
- IDLE:
  - If lock=0, winner = first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - If lock=1, only the locked requester is eligible.
  - req_ready[winner]=1, combinational, only in IDLE; all other ready bits are 0.
  - On transfer: capture req_data into tx_data, req_last into last_r, winner into grant_id; go to LAUNCH.
- LAUNCH: tx_en=1 for exactly this one cycle, with tx_data already stable; go to WAIT. Latency from accept edge to tx_en high is 1 cycle.
- WAIT: count cycles.
  - On tx_done, go to IDLE. If last_r=1: lock=0, rr_ptr=grant_id. If last_r=0: lock=1 on grant_id, rr_ptr unchanged.
  - If the count reaches TIMEOUT_CYC-1 without tx_done: go to ERR, set timeout_err=1, lock=0.
  - A tx_done arriving in the same cycle as the timeout wins: no error.
- ERR:
  - No req_ready, no tx_en.
  - err_clr=1 clears timeout_err and returns to IDLE next cycle; rr_ptr=grant_id, so the failed requester loses priority.
- Lock gap: in IDLE with lock=1 and the locked requester's req_valid=0, a gap counter increments. At LOCK_GAP-1 the lock drops (lock=0) and normal arbitration resumes next cycle. The counter resets on any transfer.
- tx_done outside WAIT is ignored.
- err_clr outside ERR is ignored.
- tx_data holds its value until the next transfer.
- Throughput: one byte per uart_tx frame. Minimum gap is tx_done, then accept (1 cycle), then tx_en (1 cycle).
- Reset mid-operation returns all state to reset values immediately; an in-flight uart_tx frame is abandoned.
- req_valid dropping without a transfer is legal (no data is lost); a held req_data must stay stable while valid=1.
- Assertions:
  - tx_en is never high on two consecutive cycles.
  - At most one req_ready bit is high.
  - tx_en is only asserted in LAUNCH.

Test Plan:
- Single byte: req_valid[0]=1, req_data=8'hA5, last=1 → req_ready[0] for 1 cycle, tx_en 1 cycle later with tx_data=8'hA5. Stub tx_done after 100 cycles → IDLE, grant_id=0.
- Round-robin: all 4 valid, last=1, stub tx_done → grant order 0,1,2,3,0; each tx_en pulse is exactly 1 cycle.
- Message lock: requester 2 sends 8'h11, 8'h22, 8'h33 with last=0,0,1 while requester 1 is valid throughout → all three bytes of requester 2 go back-to-back, then requester 3 (rr_ptr=2, requester 3 valid) or requester 1.
- Lock gap: requester 1 sends last=0, then drops valid for 16 cycles while requester 3 is valid → lock released, requester 3 granted.
- Timeout: suppress tx_done for 8192 WAIT cycles → timeout_err=1, state ERR, no req_ready. Pulse err_clr → timeout_err=0, IDLE.
- Reset during WAIT: assert rst_n=0 mid-frame → tx_en=0, busy=0, lock=0. After release, requester 0 wins first.
